// File: rtl/hsio_pkg.sv
// Shared types and widths for the HSIO pad arbiter.
// Holds the FSM state encoding and the parameter legality check used at elaboration.
package hsio_pkg;

    localparam int unsigned TURN_W = 4;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    function automatic bit params_ok(input int unsigned nreq,
                                     input int unsigned turn_cyc,
                                     input int unsigned max_hold);
        return (nreq >= 2) && (nreq <= 8) &&
               (turn_cyc >= 1) && (turn_cyc <= 15) &&
               (max_hold >= 2) && (max_hold <= 255);
    endfunction

endpackage

// File: rtl/hsio_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping.
// Purely combinational; the caller registers whatever it keeps.
module hsio_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner_c,
    output logic             valid_c
);

    always_comb begin
        int unsigned j;
        j        = 0;
        winner_c = '0;
        valid_c  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!valid_c && req[IDX_W'(j)]) begin
                valid_c  = 1'b1;
                winner_c = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/hsio_pad_arbiter.sv
// Round-robin owner arbitration for one bidirectional pad, with bounded hold
// and a forced high-Z gap between consecutive drivers.
module hsio_pad_arbiter
    import hsio_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_do,
    input  logic [NREQ-1:0] req_oe,
    output logic [NREQ-1:0] gnt,
    output logic            pad_do,
    output logic            pad_t,
    input  logic            pad_di,
    output logic            rd_data,
    output logic            busy
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    if (!params_ok(NREQ, TURN_CYC, MAX_HOLD)) begin : g_param_err
        $error("hsio_pad_arbiter: parameter out of range");
    end

    state_t            state, state_nxt;
    logic [TURN_W-1:0] turn_cnt, turn_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [IDX_W-1:0]  winner, winner_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_nxt;
    logic [IDX_W-1:0]  ptr_after, pick_ptr, pick_idx_c;
    logic [NREQ-1:0]   win_oh, others, pick_req, gnt_nxt;
    logic              pick_valid_c, release_own;

    assign win_oh      = NREQ'(1) << winner;
    assign others      = req & ~win_oh;
    assign ptr_after   = (32'(winner) == NREQ - 1) ? '0 : winner + IDX_W'(1);
    assign release_own = !req[winner] ||
                         ((hold_cnt >= HOLD_W'(MAX_HOLD - 1)) && (|others));

    // On release the current owner is excluded and the search starts just past it.
    assign pick_req = (state == OWN) ? others : req;
    assign pick_ptr = (state == OWN) ? ptr_after : rr_ptr;

    hsio_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (pick_req),
        .ptr      (pick_ptr),
        .winner_c (pick_idx_c),
        .valid_c  (pick_valid_c)
    );

    always_comb begin
        state_nxt  = state;
        turn_nxt   = turn_cnt;
        hold_nxt   = hold_cnt;
        winner_nxt = winner;
        rr_nxt     = rr_ptr;
        gnt_nxt    = '0;
        unique case (state)
            IDLE: begin
                if (pick_valid_c) begin
                    winner_nxt = pick_idx_c;
                    turn_nxt   = TURN_W'(TURN_CYC);
                    state_nxt  = TURN;
                end
            end
            TURN: begin
                if (!req[winner]) begin
                    state_nxt = IDLE;
                end else if (turn_cnt == TURN_W'(1)) begin
                    hold_nxt  = '0;
                    state_nxt = OWN;
                end else begin
                    turn_nxt = turn_cnt - TURN_W'(1);
                end
            end
            OWN: begin
                if (release_own) begin
                    rr_nxt = ptr_after;
                    if (pick_valid_c) begin
                        winner_nxt = pick_idx_c;
                        turn_nxt   = TURN_W'(TURN_CYC);
                        state_nxt  = TURN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt < HOLD_W'(MAX_HOLD)) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == OWN) begin
            gnt_nxt = NREQ'(1) << winner_nxt;
        end
    end

    // Pad controls follow the registered grant, so a driver is only ever enabled one cycle after its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            turn_cnt <= '0;
            hold_cnt <= '0;
            winner   <= '0;
            rr_ptr   <= '0;
            gnt      <= '0;
            pad_t    <= 1'b1;
            pad_do   <= 1'b0;
            rd_data  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            turn_cnt <= turn_nxt;
            hold_cnt <= hold_nxt;
            winner   <= winner_nxt;
            rr_ptr   <= rr_nxt;
            gnt      <= gnt_nxt;
            pad_t    <= ~(|(gnt & req_oe));
            pad_do   <= |(gnt & req_do & req_oe);
            rd_data  <= pad_di;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule
